fft_bitrev_inbuf: RTL and testbench

//  Input stage ahead of the radix-2 butterfly of the 64-point FFT. Accepts one complex

---
 rtl/fft_bitrev_inbuf.sv | 142 ++++++++++++++
 tb/tb_fft_bitrev_inbuf.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_inbuf.sv
// Bit-reversing ping-pong input buffer ahead of the radix-2 butterfly of the 64-point FFT.
// Define FFT_INBUF_LAST_CHK_EN to add the in_last_i framing check and sticky frame_err_o.
`ifndef DATA_WID
`define DATA_WID 16
`endif

module fft_bitrev_inbuf #(
  parameter int N_LOG2 = 6,
  parameter int DW     = `DATA_WID
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic signed [DW-1:0] in_re_i,
  input  logic signed [DW-1:0] in_im_i,
`ifdef FFT_INBUF_LAST_CHK_EN
  input  logic                 in_last_i,
  output logic                 frame_err_o,
`endif
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic signed [DW-1:0] out_re1_o,
  output logic signed [DW-1:0] out_im1_o,
  output logic signed [DW-1:0] out_re2_o,
  output logic signed [DW-1:0] out_im2_o,
  output logic [N_LOG2-2:0]    out_idx_o,
  output logic                 out_last_o
);

  localparam int N = 1 << N_LOG2;

  logic signed [DW-1:0] r_re [2][N];
  logic signed [DW-1:0] r_im [2][N];

  logic [N_LOG2-1:0] r_wr_cnt;
  logic [N_LOG2-2:0] r_rd_cnt;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [1:0]        r_full;

  logic              w_wr_fire;
  logic              w_wr_end;
  logic              w_rd_load;
  logic              w_rd_end;
  logic              w_commit;
  logic              w_abort;
  logic [1:0]        w_full_nxt;
  logic [N_LOG2-1:0] w_wr_addr;
  logic [N_LOG2-1:0] w_rd_addr0;
  logic [N_LOG2-1:0] w_rd_addr1;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) r[i] = a[N_LOG2-1-i];
    return r;
  endfunction

  assign in_ready_o = ~r_full[r_wr_bank];
  assign w_wr_fire  = in_valid_i & in_ready_o;
  assign w_wr_end   = (r_wr_cnt == '1);
  assign w_rd_load  = (~out_valid_o | out_ready_i) & r_full[r_rd_bank];
  assign w_rd_end   = (r_rd_cnt == '1);
  assign w_wr_addr  = bitrev(r_wr_cnt);
  assign w_rd_addr0 = {r_rd_cnt, 1'b0};
  assign w_rd_addr1 = {r_rd_cnt, 1'b1};
  assign w_commit   = w_wr_fire & w_wr_end;

`ifdef FFT_INBUF_LAST_CHK_EN
  // An early last closes the frame without committing it; a missing last still commits.
  assign w_abort = w_wr_fire & in_last_i & ~w_wr_end;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_err_o <= 1'b0;
    end else if (w_wr_fire && (in_last_i != w_wr_end)) begin
      frame_err_o <= 1'b1;
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  // Set and clear always target different banks, so both can happen in one cycle.
  always_comb begin
    w_full_nxt = r_full;
    if (w_commit) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rd_load && w_rd_end) w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_fire) begin
      r_re[r_wr_bank][w_wr_addr] <= in_re_i;
      r_im[r_wr_bank][w_wr_addr] <= in_im_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_full      <= '0;
      out_valid_o <= 1'b0;
      out_re1_o   <= '0;
      out_im1_o   <= '0;
      out_re2_o   <= '0;
      out_im2_o   <= '0;
      out_idx_o   <= '0;
      out_last_o  <= 1'b0;
    end else begin
      r_full <= w_full_nxt;

      if (w_abort) begin
        r_wr_cnt <= '0;
      end else if (w_wr_fire) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
        if (w_wr_end) r_wr_bank <= ~r_wr_bank;
      end

      if (w_rd_load) begin
        out_valid_o <= 1'b1;
        out_re1_o   <= r_re[r_rd_bank][w_rd_addr0];
        out_im1_o   <= r_im[r_rd_bank][w_rd_addr0];
        out_re2_o   <= r_re[r_rd_bank][w_rd_addr1];
        out_im2_o   <= r_im[r_rd_bank][w_rd_addr1];
        out_idx_o   <= r_rd_cnt;
        out_last_o  <= w_rd_end;
        if (w_rd_end) begin
          r_rd_cnt  <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
        end
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_inbuf.sv
// Scoreboard bench for fft_bitrev_inbuf: a driver pushes expected bit-reversed pairs,
// a negedge monitor pops and compares them; also checks hold stability and async reset.
module tb_fft_bitrev_inbuf;
  localparam int N_LOG2 = 6;
  localparam int N      = 64;
  localparam int NP     = 32;
  localparam int DW     = 16;

  typedef struct packed {
    logic [DW-1:0] re1;
    logic [DW-1:0] im1;
    logic [DW-1:0] re2;
    logic [DW-1:0] im2;
    logic [4:0]    idx;
    logic          last;
  } pair_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          in_valid_i = 1'b0;
  logic [DW-1:0] in_re_i = '0;
  logic [DW-1:0] in_im_i = '0;
  logic          out_ready_i = 1'b0;
  logic          in_ready_o;
  logic          out_valid_o;
  logic [DW-1:0] out_re1_o, out_im1_o, out_re2_o, out_im2_o;
  logic [4:0]    out_idx_o;
  logic          out_last_o;
`ifdef FFT_INBUF_LAST_CHK_EN
  logic          in_last_i = 1'b0;
  logic          frame_err_o;
`endif

  fft_bitrev_inbuf #(.N_LOG2(N_LOG2), .DW(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_re_i     (in_re_i),
    .in_im_i     (in_im_i),
`ifdef FFT_INBUF_LAST_CHK_EN
    .in_last_i   (in_last_i),
    .frame_err_o (frame_err_o),
`endif
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_re1_o   (out_re1_o),
    .out_im1_o   (out_im1_o),
    .out_re2_o   (out_re2_o),
    .out_im2_o   (out_im2_o),
    .out_idx_o   (out_idx_o),
    .out_last_o  (out_last_o)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            stalls = 0;
  int            readyMode = 0;
  int            wcnt = 0;
  logic          lastReq = 1'b0;
  pair_t         expQ[$];
  pair_t         recvLog[$];
  logic [DW-1:0] frRe[N];
  logic [DW-1:0] frIm[N];

  function automatic int bitrevTb(input int a);
    int r = 0;
    for (int i = 0; i < N_LOG2; i++) if ((a & (1 << i)) != 0) r |= 1 << (N_LOG2 - 1 - i);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: collect a natural-order frame, then queue its bit-reversed pairs.
  task automatic modelAccept(input logic [DW-1:0] re, input logic [DW-1:0] im);
    pair_t p;
    frRe[wcnt] = re;
    frIm[wcnt] = im;
`ifdef FFT_INBUF_LAST_CHK_EN
    if (lastReq && wcnt != N - 1) begin
      wcnt = 0;
      return;
    end
`endif
    if (wcnt == N - 1) begin
      for (int k = 0; k < NP; k++) begin
        p.re1  = frRe[bitrevTb(2 * k)];
        p.im1  = frIm[bitrevTb(2 * k)];
        p.re2  = frRe[bitrevTb(2 * k + 1)];
        p.im2  = frIm[bitrevTb(2 * k + 1)];
        p.idx  = 5'(k);
        p.last = (k == NP - 1);
        expQ.push_back(p);
      end
      wcnt = 0;
    end else begin
      wcnt++;
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] re, input logic [DW-1:0] im);
    bit acc = 0;
    int guard = 0;
    in_re_i    = re;
    in_im_i    = im;
    in_valid_i = 1'b1;
`ifdef FFT_INBUF_LAST_CHK_EN
    in_last_i  = lastReq;
`endif
    while (!acc && guard < 2000) begin
      @(negedge clk);
      acc = in_ready_o;
      if (acc) modelAccept(re, im);
      else stalls++;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) checkOutput("accept_timeout", 80'(acc), 80'(1));
  endtask

  task automatic idle(input int n);
    in_valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendFrame(input int mode, input int f, input bit gaps);
    logic [DW-1:0] re, im;
    for (int n = 0; n < N; n++) begin
      case (mode)
        0:       begin re = 16'(n);                im = 16'(-n); end
        1:       begin re = 16'(n * 257 + f * 4369); im = ~re;      end
        default: begin re = 16'($urandom);         im = 16'($urandom); end
      endcase
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      applyStimulus(re, im);
    end
  endtask

  task automatic drain(input string name);
    int g = 0;
    in_valid_i = 1'b0;
    readyMode  = 1;
    while (expQ.size() != 0 && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    idle(3);
    checkOutput(name, 80'(expQ.size()), 80'(0));
  endtask

  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       out_ready_i = 1'b0;
      1:       out_ready_i = 1'b1;
      default: out_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops one expected pair per transfer and checks that stalled outputs hold.
  pair_t cur;
  pair_t held;
  bit    holdV = 0;
  always @(negedge clk) begin
    cur = '{re1: out_re1_o, im1: out_im1_o, re2: out_re2_o, im2: out_im2_o,
            idx: out_idx_o, last: out_last_o};
    if (rst_i) begin
      holdV = 0;
    end else begin
      if (holdV) checkOutput("hold_stable", {9'b0, out_valid_o, cur}, {9'b0, 1'b1, held});
      if (out_valid_o && !out_ready_i) begin
        holdV = 1;
        held  = cur;
      end else begin
        holdV = 0;
      end
      if (out_valid_o && out_ready_i) begin
        recvLog.push_back(cur);
        if (expQ.size() == 0) checkOutput("unexpected_pair", 80'(cur), 80'(0));
        else checkOutput("pair_data", 80'(cur), 80'(expQ.pop_front()));
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 80'(out_valid_o), 80'(0));
    checkOutput("rst_ready", 80'(in_ready_o), 80'(1));
    checkOutput("rst_data", {out_re1_o, out_im1_o, out_re2_o, out_im2_o, out_idx_o, out_last_o}, 80'(0));
    rst_i = 1'b0;
    readyMode = 1;
    idle(2);

    // Ramp frame with hand-checked spot pairs
    recvLog.delete();
    sendFrame(0, 0, 0);
    drain("ramp_drain");
    checkOutput("ramp_count", 80'(recvLog.size()), 80'(32));
    checkOutput("ramp_p0", {recvLog[0].re1, recvLog[0].re2, recvLog[0].im2, recvLog[0].idx},
                {16'd0, 16'd32, 16'hFFE0, 5'd0});
    checkOutput("ramp_p1", {recvLog[1].re1, recvLog[1].re2, recvLog[1].idx}, {16'd16, 16'd48, 5'd1});
    checkOutput("ramp_p31", {recvLog[31].re1, recvLog[31].re2, recvLog[31].idx, recvLog[31].last},
                {16'd31, 16'd63, 5'd31, 1'b1});

    // Three frames back to back, never stalled
    recvLog.delete();
    stalls = 0;
    for (int f = 0; f < 3; f++) sendFrame(1, f, 0);
    checkOutput("b2b_no_stall", 80'(stalls), 80'(0));
    drain("b2b_drain");
    checkOutput("b2b_count", 80'(recvLog.size()), 80'(96));

    // Backpressure: both banks fill, pair 0 held
    recvLog.delete();
    readyMode = 0;
    stalls = 0;
    idle(2);
    sendFrame(1, 5, 0);
    sendFrame(1, 6, 0);
    idle(1);
    checkOutput("bp_no_stall", 80'(stalls), 80'(0));
    checkOutput("bp_ready_low", 80'(in_ready_o), 80'(0));
    idle(100);
    checkOutput("bp_still_full", {out_valid_o, in_ready_o, out_idx_o}, {1'b1, 1'b0, 5'd0});
    drain("bp_drain");
    checkOutput("bp_count", 80'(recvLog.size()), 80'(64));
    checkOutput("bp_ready_back", 80'(in_ready_o), 80'(1));

    // Random ready and input gaps
    readyMode = 2;
    sendFrame(2, 0, 1);
    sendFrame(2, 1, 1);
    drain("rand_drain");

    // Async reset mid-cycle with a held pair and a partial frame in flight
    readyMode = 0;
    idle(2);
    sendFrame(1, 9, 0);
    for (int n = 0; n < 20; n++) applyStimulus(16'(n), 16'(n));
    idle(1);
    @(posedge clk);
    #3;
    rst_i = 1'b1;
    #1;
    checkOutput("async_rst", {out_valid_o, in_ready_o, out_idx_o, out_last_o, out_re1_o},
                {1'b0, 1'b1, 5'd0, 1'b0, 16'd0});
    expQ.delete();
    wcnt = 0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    readyMode = 1;
    recvLog.delete();
    idle(2);
    sendFrame(1, 11, 0);
    drain("post_rst_drain");
    checkOutput("post_rst_count", 80'(recvLog.size()), 80'(32));

`ifdef FFT_INBUF_LAST_CHK_EN
    // Early last at sample 10 flags an error; the next 64 samples form a clean frame
    recvLog.delete();
    for (int n = 0; n < 11; n++) begin
      lastReq = (n == 10);
      applyStimulus(16'(n + 100), 16'(n));
    end
    lastReq = 1'b0;
    idle(1);
    checkOutput("early_last_err", 80'(frame_err_o), 80'(1));
    for (int n = 0; n < N; n++) begin
      lastReq = (n == N - 1);
      applyStimulus(16'(n * 3), 16'(n * 5));
    end
    lastReq = 1'b0;
    drain("err_frame_drain");
    checkOutput("err_frame_count", 80'(recvLog.size()), 80'(32));
    rst_i = 1'b1;
    idle(2);
    rst_i = 1'b0;
    wcnt = 0;
    idle(1);
    for (int n = 0; n < N; n++) begin
      lastReq = (n == N - 1);
      applyStimulus(16'(n), 16'(n));
    end
    lastReq = 1'b0;
    drain("good_last_drain");
    checkOutput("good_last_err", 80'(frame_err_o), 80'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
